// File: rtl/pe_vector_seq.sv
//==============================================================================
// Module   : pe_vector_seq
// Purpose  : Issues SET/LOAD_IFMAP/LOAD_WGHT/CONV[/ACC] to one PE vector and
//            streams its GLB operands. Macro PE_SEQ_ACC_EN adds ACC + psum.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pe_vector_seq #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [8:0]               i_conv_info,
    input  logic [ADDR_BITWIDTH-1:0] i_ifmap_base,
    input  logic [ADDR_BITWIDTH-1:0] i_wght_base,
    input  logic [ADDR_BITWIDTH-1:0] i_psum_base,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ADDR_BITWIDTH-1:0] o_glb_raddr,
    output logic                     o_glb_ren,
    input  logic [DATA_BITWIDTH-1:0] i_glb_rdata,
    output logic [2:0]               o_inst_data,
    output logic [8:0]               o_conv_info,
    output logic                     o_inst_valid,
    input  logic                     i_inst_ready,
    output logic [DATA_BITWIDTH-1:0] o_ifmap_data,
    output logic                     o_ifmap_valid,
    input  logic                     i_ifmap_ready,
    output logic [DATA_BITWIDTH-1:0] o_wght_data,
    output logic                     o_wght_valid,
    input  logic                     i_wght_ready,
    output logic [DATA_BITWIDTH-1:0] o_psum_in_data,
    output logic                     o_psum_in_valid,
    input  logic                     i_psum_in_ready
);

    // State codes of the command states double as their command codes.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SET      = 3'd1;
    localparam logic [2:0] S_LD_IFMAP = 3'd2;
    localparam logic [2:0] S_LD_WGHT  = 3'd3;
    localparam logic [2:0] S_CONV     = 3'd4;
    localparam logic [2:0] S_ACC      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] C_NOP      = 3'd0;

    localparam logic [1:0] PH_CMD  = 2'd0;
    localparam logic [1:0] PH_DEC  = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;

    logic [2:0]               state_q, state_d;
    logic [1:0]               phase_q, phase_d;
    logic [8:0]               conv_info_q;
    logic [ADDR_BITWIDTH-1:0] ifmap_base_q, wght_base_q;
    logic [8:0]               rd_cnt_q, xfer_cnt_q;
    logic [DATA_BITWIDTH-1:0] fifo_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               fifo_cnt_q;
    logic                     inflight_q;
`ifdef PE_SEQ_ACC_EN
    logic [ADDR_BITWIDTH-1:0] psum_base_q;
`else
    logic                     w_unused_psum;
    assign w_unused_psum = ^{i_psum_base, i_psum_in_ready};
`endif

    logic [5:0]               w_qs;
    logic [8:0]               w_pqs, w_total;
    logic [ADDR_BITWIDTH-1:0] w_base;
    logic [2:0]               w_next;
    logic [DATA_BITWIDTH-1:0] w_head;
    logic w_start_ok, w_cmd_state, w_stream, w_ready, w_valid;
    logic w_pop, w_fifo_pop, w_push, w_ren, w_adv;

    assign w_qs        = {3'd0, conv_info_q[5:3]} * {3'd0, conv_info_q[2:0]};
    assign w_pqs       = {6'd0, conv_info_q[8:6]} * {3'd0, w_qs};
    assign w_start_ok  = (state_q == S_IDLE) && i_start && (i_conv_info[8:6] != 3'd0)
                         && (i_conv_info[5:3] != 3'd0) && (i_conv_info[2:0] != 3'd0);
    assign w_cmd_state = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_stream    = (phase_q != PH_CMD) && ((state_q == S_LD_IFMAP) ||
                         (state_q == S_LD_WGHT) || (state_q == S_ACC));

    always_comb begin
        w_total = 9'd0;
        w_base  = '0;
        w_ready = 1'b0;
        case (state_q)
            S_LD_IFMAP: begin
                w_total = {3'd0, w_qs};
                w_base  = ifmap_base_q;
                w_ready = i_ifmap_ready;
            end
            S_LD_WGHT: begin
                w_total = w_pqs;
                w_base  = wght_base_q;
                w_ready = i_wght_ready;
            end
            S_CONV: w_total = w_pqs;
`ifdef PE_SEQ_ACC_EN
            S_ACC: begin
                w_total = {6'd0, conv_info_q[8:6]};
                w_base  = psum_base_q;
                w_ready = i_psum_in_ready;
            end
`endif
            default: ;
        endcase
    end

    // An in-flight read is presented straight from the GLB port so the first
    // word is visible in the first DATA cycle; it is parked only if stalled.
    assign w_valid    = w_stream && ((fifo_cnt_q != 2'd0) || inflight_q);
    assign w_head     = (fifo_cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : i_glb_rdata;
    assign w_pop      = w_valid && w_ready;
    assign w_fifo_pop = w_pop && (fifo_cnt_q != 2'd0);
    assign w_push     = inflight_q && !(w_pop && (fifo_cnt_q == 2'd0));
    assign w_ren      = w_stream && (rd_cnt_q < w_total) &&
                        (({1'b0, fifo_cnt_q} + {2'd0, inflight_q}) < 3'd2);

    always_comb begin
        w_adv = 1'b0;
        if (phase_q == PH_DATA) begin
            if (state_q == S_CONV)
                w_adv = (xfer_cnt_q == w_total - 9'd1);
            else
                w_adv = w_pop && (xfer_cnt_q == w_total - 9'd1);
        end
    end

    always_comb begin
        case (state_q)
            S_SET:      w_next = S_LD_IFMAP;
            S_LD_IFMAP: w_next = S_LD_WGHT;
            S_LD_WGHT:  w_next = S_CONV;
`ifdef PE_SEQ_ACC_EN
            S_CONV:     w_next = S_ACC;
`else
            S_CONV:     w_next = S_DONE;
`endif
            default:    w_next = S_DONE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            phase_q <= PH_CMD;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d = S_SET;
                    phase_d = PH_CMD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                case (phase_q)
                    PH_CMD: if (i_inst_ready) phase_d = PH_DEC;
                    PH_DEC: begin
                        if (state_q == S_SET) begin
                            state_d = w_next;
                            phase_d = PH_CMD;
                        end else begin
                            phase_d = PH_DATA;
                        end
                    end
                    default: begin
                        if (w_adv) begin
                            state_d = w_next;
                            phase_d = PH_CMD;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conv_info_q  <= 9'd0;
            ifmap_base_q <= '0;
            wght_base_q  <= '0;
`ifdef PE_SEQ_ACC_EN
            psum_base_q  <= '0;
`endif
            rd_cnt_q     <= 9'd0;
            xfer_cnt_q   <= 9'd0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                conv_info_q  <= i_conv_info;
                ifmap_base_q <= i_ifmap_base;
                wght_base_q  <= i_wght_base;
`ifdef PE_SEQ_ACC_EN
                psum_base_q  <= i_psum_base;
`endif
            end
            if (state_d != state_q) begin
                rd_cnt_q   <= 9'd0;
                xfer_cnt_q <= 9'd0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                fifo_cnt_q <= 2'd0;
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= w_ren;
                if (w_ren)
                    rd_cnt_q <= rd_cnt_q + 9'd1;
                if (w_pop || ((state_q == S_CONV) && (phase_q == PH_DATA)))
                    xfer_cnt_q <= xfer_cnt_q + 9'd1;
                if (w_push) begin
                    fifo_q[wr_ptr_q] <= i_glb_rdata;
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (w_fifo_pop)
                    rd_ptr_q <= ~rd_ptr_q;
                fifo_cnt_q <= fifo_cnt_q + {1'b0, w_push} - {1'b0, w_fifo_pop};
            end
        end
    end

    always_comb begin
        o_busy        = (state_q != S_IDLE);
        o_done        = (state_q == S_DONE);
        o_inst_valid  = w_cmd_state && (phase_q == PH_CMD);
        o_inst_data   = o_inst_valid ? state_q : C_NOP;
        o_conv_info   = conv_info_q;
        o_glb_ren     = w_ren;
        o_glb_raddr   = w_ren ? (w_base + ADDR_BITWIDTH'(rd_cnt_q)) : '0;
        o_ifmap_valid = w_valid && (state_q == S_LD_IFMAP);
        o_ifmap_data  = o_ifmap_valid ? w_head : '0;
        o_wght_valid  = w_valid && (state_q == S_LD_WGHT);
        o_wght_data   = o_wght_valid ? w_head : '0;
`ifdef PE_SEQ_ACC_EN
        o_psum_in_valid = w_valid && (state_q == S_ACC);
        o_psum_in_data  = o_psum_in_valid ? w_head : '0;
`else
        o_psum_in_valid = 1'b0;
        o_psum_in_data  = '0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_vector_seq.sv
//==============================================================================
// Module   : tb_pe_vector_seq
// Purpose  : Directed self-checking bench for pe_vector_seq (PE_SEQ_ACC_EN aware).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pe_vector_seq;
    localparam int DW = 8;
    localparam int AW = 10;
`ifdef PE_SEQ_ACC_EN
    localparam int          EXP_NCMD = 5;
    localparam logic [14:0] EXP_SEQ  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    localparam int          EXP_NPS  = 6;
`else
    localparam int          EXP_NCMD = 4;
    localparam logic [14:0] EXP_SEQ  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    localparam int          EXP_NPS  = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [8:0]    conv_info;
    logic [AW-1:0] ifmap_base, wght_base, psum_base;
    logic [DW-1:0] glb_rdata;
    logic          inst_ready, ifmap_ready, wght_ready, psum_ready;
    logic          o_busy, o_done, o_glb_ren, o_inst_valid;
    logic [AW-1:0] o_glb_raddr;
    logic [2:0]    o_inst_data;
    logic [8:0]    o_conv_info;
    logic [DW-1:0] o_ifmap_data, o_wght_data, o_psum_in_data;
    logic          o_ifmap_valid, o_wght_valid, o_psum_in_valid;

    pe_vector_seq #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_conv_info(conv_info),
        .i_ifmap_base(ifmap_base), .i_wght_base(wght_base), .i_psum_base(psum_base),
        .o_busy(o_busy), .o_done(o_done), .o_glb_raddr(o_glb_raddr), .o_glb_ren(o_glb_ren),
        .i_glb_rdata(glb_rdata), .o_inst_data(o_inst_data), .o_conv_info(o_conv_info),
        .o_inst_valid(o_inst_valid), .i_inst_ready(inst_ready),
        .o_ifmap_data(o_ifmap_data), .o_ifmap_valid(o_ifmap_valid), .i_ifmap_ready(ifmap_ready),
        .o_wght_data(o_wght_data), .o_wght_valid(o_wght_valid), .i_wght_ready(wght_ready),
        .o_psum_in_data(o_psum_in_data), .o_psum_in_valid(o_psum_in_valid),
        .i_psum_in_ready(psum_ready)
    );

    function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5 ^ {4{a[9:8]}};
    endfunction

    // GLB model: one-cycle read latency, junk when not reading.
    always @(posedge clk) glb_rdata <= o_glb_ren ? glb_word(o_glb_raddr) : 8'hEE;

    wire [52:0] outs = {o_busy, o_done, o_inst_valid, o_inst_data, o_glb_ren, o_glb_raddr,
                        o_conv_info, o_ifmap_valid, o_ifmap_data, o_wght_valid, o_wght_data,
                        o_psum_in_valid, o_psum_in_data};

    int checks = 0;
    int failures = 0;
    int n_cmd, n_if, n_w, n_ps, bad_if, bad_w, bad_ps, inst_unstable, s_unstable, dec_bad;
    int multi, ps_seen, n_done, stall_cyc, conv_bad, any_act;
    int set_acc, if_acc, if_rise, conv_acc, post_conv, if_first, if_last;
    int busy_c1, busy_c2, iv_c2;
    bit got_done;
    logic [14:0]   cmd_seq;
    logic [8:0]    exp_ci;
    logic [AW-1:0] cur_ifb, cur_wb, cur_pb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_prog(input logic [8:0] ci, input logic [AW-1:0] a,
                              input logic [AW-1:0] b, input logic [AW-1:0] d);
        @(posedge clk); #1;
        conv_info = ci; ifmap_base = a; wght_base = b; psum_base = d;
        cur_ifb = a; cur_wb = b; cur_pb = d; exp_ci = ci;
        start = 1'b1;
    endtask

    task automatic run(input int max_cyc, input int abort_w, input bit tog_w,
                       input bit slow_inst, input bit late_start);
        int            wait_cnt = 0;
        logic [2:0]    vld, rdy;
        logic [2:0]    p_vld = 3'b000;
        logic [2:0]    p_rdy = 3'b000;
        logic [DW-1:0] dat [3];
        logic [DW-1:0] p_dat [3];
        logic          p_iv = 1'b0, p_ir = 1'b0, p_acc = 1'b0;
        logic [2:0]    p_id = 3'd0;
        n_cmd = 0; n_if = 0; n_w = 0; n_ps = 0; bad_if = 0; bad_w = 0; bad_ps = 0;
        inst_unstable = 0; s_unstable = 0; dec_bad = 0; multi = 0; ps_seen = 0; n_done = 0;
        stall_cyc = 0; conv_bad = 0; any_act = 0; set_acc = 0; if_acc = 0; if_rise = 0;
        conv_acc = 0; post_conv = 0; if_first = 0; if_last = 0; busy_c1 = 0; busy_c2 = 0;
        iv_c2 = 0; got_done = 1'b0; cmd_seq = 15'd0;
        p_dat[0] = '0; p_dat[1] = '0; p_dat[2] = '0;
        ifmap_ready = 1'b1; wght_ready = 1'b1; psum_ready = 1'b1; inst_ready = !slow_inst;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = int'(o_busy);
            if (c == 2) begin busy_c2 = int'(o_busy); iv_c2 = int'(o_inst_valid); end
            if (o_busy && (o_conv_info !== exp_ci)) conv_bad++;
            if (o_busy || o_inst_valid || o_done) any_act++;
            if (p_iv && !p_ir && (!o_inst_valid || (o_inst_data !== p_id))) inst_unstable++;
            if (p_acc && o_inst_valid) dec_bad++;
            if (o_inst_valid && !inst_ready) stall_cyc++;
            if (conv_acc != 0 && post_conv == 0 && (o_done || o_inst_valid)) post_conv = c;
            if (o_inst_valid && o_inst_data == 3'd2 && if_rise == 0) if_rise = c;
            p_acc = o_inst_valid && inst_ready;
            if (p_acc) begin
                n_cmd++;
                cmd_seq = {cmd_seq[11:0], o_inst_data};
                if (o_inst_data == 3'd1) set_acc = c;
                if (o_inst_data == 3'd2) if_acc = c;
                if (o_inst_data == 3'd4) conv_acc = c;
            end
            vld = {o_psum_in_valid, o_wght_valid, o_ifmap_valid};
            rdy = {psum_ready, wght_ready, ifmap_ready};
            dat[0] = o_ifmap_data; dat[1] = o_wght_data; dat[2] = o_psum_in_data;
            if ($countones(vld) > 1) multi++;
            if (o_psum_in_valid) ps_seen++;
            for (int i = 0; i < 3; i++)
                if (p_vld[i] && !p_rdy[i] && (!vld[i] || (dat[i] !== p_dat[i]))) s_unstable++;
            if (vld[0] && rdy[0]) begin
                if (n_if == 0) if_first = c;
                if_last = c;
                if (dat[0] !== glb_word(cur_ifb + 10'(n_if))) bad_if++;
                n_if++;
            end
            if (vld[1] && rdy[1]) begin
                if (dat[1] !== glb_word(cur_wb + 10'(n_w))) bad_w++;
                n_w++;
            end
            if (vld[2] && rdy[2]) begin
                if (dat[2] !== glb_word(cur_pb + 10'(n_ps))) bad_ps++;
                n_ps++;
            end
            p_vld = vld; p_rdy = rdy; p_dat = dat;
            p_iv = o_inst_valid; p_ir = inst_ready; p_id = o_inst_data;
            if (o_done) begin
                n_done++;
                got_done = 1'b1;
                break;
            end
            if (abort_w != 0 && n_w >= abort_w) break;
            @(posedge clk); #1;
            start = 1'b0;
            if (late_start && c == 20) begin
                start = 1'b1;
                conv_info = 9'b001001001;
            end
            if (tog_w) wght_ready = ~wght_ready;
            if (slow_inst) begin
                if (o_inst_valid) begin
                    inst_ready = (wait_cnt >= 5);
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    inst_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; conv_info = 9'd0;
        ifmap_base = '0; wght_base = '0; psum_base = '0;
        inst_ready = 1'b0; ifmap_ready = 1'b0; wght_ready = 1'b0; psum_ready = 1'b0;
        exp_ci = 9'd0; cur_ifb = '0; cur_wb = '0; cur_pb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outs), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 64'(outs), 64'd0);

        // Full program, all readies high.
        start_prog(9'b110100011, 10'd0, 10'd64, 10'd256);
        run(600, 0, 1'b0, 1'b0, 1'b0);
        check("full_done", 64'(got_done), 64'd1);
        check("full_busy_at_start", 64'(busy_c1), 64'd0);
        check("full_busy_after_start", 64'(busy_c2), 64'd1);
        check("full_set_valid_next_cycle", 64'(iv_c2), 64'd1);
        check("full_cmd_count", 64'(n_cmd), 64'(EXP_NCMD));
        check("full_cmd_order", 64'(cmd_seq), 64'(EXP_SEQ));
        check("full_set_dec_gap", 64'(if_rise - set_acc), 64'd2);
        check("full_ifmap_count", 64'(n_if), 64'd12);
        check("full_ifmap_data", 64'(bad_if), 64'd0);
        check("full_ifmap_fill", 64'(if_first - if_acc), 64'd2);
        check("full_ifmap_rate", 64'(if_last - if_first), 64'd11);
        check("full_wght_count", 64'(n_w), 64'd72);
        check("full_wght_data", 64'(bad_w), 64'd0);
        check("full_conv_wait", 64'(post_conv - conv_acc), 64'd74);
        check("full_psum_count", 64'(n_ps), 64'(EXP_NPS));
        check("full_psum_data", 64'(bad_ps), 64'd0);
        check("full_psum_valid_cycles", 64'(ps_seen), 64'(EXP_NPS));
        check("full_one_stream", 64'(multi), 64'd0);
        check("full_conv_info_held", 64'(conv_bad), 64'd0);
        @(negedge clk);
        check("full_idle_after_done", 64'({o_busy, o_done}), 64'd0);

        // Q=0: start ignored.
        start_prog(9'b110000011, 10'd0, 10'd64, 10'd256);
        run(8, 0, 1'b0, 1'b0, 1'b0);
        check("q0_no_activity", 64'(any_act), 64'd0);
        check("q0_no_cmd", 64'(n_cmd), 64'd0);

        // Weight backpressure, slow command ready, stray start while busy.
        start_prog(9'b110100011, 10'd0, 10'd64, 10'd256);
        run(1500, 0, 1'b1, 1'b1, 1'b1);
        check("bp_done", 64'(got_done), 64'd1);
        check("bp_done_once", 64'(n_done), 64'd1);
        check("bp_cmd_order", 64'(cmd_seq), 64'(EXP_SEQ));
        check("bp_cmd_stall_cycles", 64'(stall_cyc), 64'(5 * EXP_NCMD));
        check("bp_cmd_stable", 64'(inst_unstable), 64'd0);
        check("bp_dec_gap", 64'(dec_bad), 64'd0);
        check("bp_set_dec_gap", 64'(if_rise - set_acc), 64'd2);
        check("bp_ifmap_count", 64'(n_if), 64'd12);
        check("bp_wght_count", 64'(n_w), 64'd72);
        check("bp_wght_data", 64'(bad_w), 64'd0);
        check("bp_stream_stable", 64'(s_unstable), 64'd0);
        check("bp_psum_count", 64'(n_ps), 64'(EXP_NPS));
        check("bp_stray_start_ignored", 64'(conv_bad), 64'd0);

        // Reset in the middle of LD_WGHT, then a clean rerun.
        conv_info = 9'd0;
        start_prog(9'b110100011, 10'd0, 10'd64, 10'd256);
        run(600, 30, 1'b0, 1'b0, 1'b0);
        check("rst_reached_30_words", 64'(n_w), 64'd30);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("rst_async_outputs", 64'(outs), 64'd0);
        @(negedge clk);
        check("rst_held_outputs", 64'(outs), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        start_prog(9'b110100011, 10'd0, 10'd64, 10'd256);
        run(600, 0, 1'b0, 1'b0, 1'b0);
        check("rerun_done", 64'(got_done), 64'd1);
        check("rerun_cmd_order", 64'(cmd_seq), 64'(EXP_SEQ));
        check("rerun_ifmap_data", 64'({n_if, bad_if}), 64'({32'd12, 32'd0}));
        check("rerun_wght_data", 64'({n_w, bad_w}), 64'({32'd72, 32'd0}));
        check("rerun_psum_data", 64'({n_ps, bad_ps}), 64'({EXP_NPS, 32'd0}));
        check("rerun_conv_wait", 64'(post_conv - conv_acc), 64'd74);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
